awb_gain_estimator: RTL and testbench
=====================================

// Module: awb_gain_estimator
// PURPOSE
//  Automatic white-balance statistics engine on the DVI-out RGB stream. It accumulates
//  per-channel sums over one frame and computes the integer gains, in SHIFT_DIV
//  fixed-point format, that equalise red and blue to green. The gains feed the
//  runtime-gain inputs of the downstream colour-balance stage, where
//  out = (in >> SHIFT_DIV) * gain, saturated to 8 bits.
// PARAMETERS
//  SHIFT_DIV   2        fractional bits of the gain; unity gain = 1<<SHIFT_DIV
//  GAIN_W      4        gain output width; GAIN_MAX = 2**GAIN_W-1
//  ACC_W       32       per-channel accumulator width
//  SAT_THRESH  8'hF0    pixel excluded if any channel >= SAT_THRESH
//  MIN_PIXELS  16       frames with fewer counted pixels leave the gains unchanged
// PORTS
//  clk            in   1       single clock; all logic is posedge
//  rst_n          in   1       synchronous, active-low reset
//  rgb_in         in   24      {R[23:16],G[15:8],B[7:0]}
//  rgb_in_valid   in   1       pixel qualifier
//  frame_start    in   1       1-cycle pulse: clear accumulators, begin new frame
//  frame_end      in   1       1-cycle pulse: close frame, launch gain computation
//  gain_red       out  GAIN_W  red gain (reset: 1<<SHIFT_DIV)
//  gain_green     out  GAIN_W  constant 1<<SHIFT_DIV (reference channel)
//  gain_blue      out  GAIN_W  blue gain (reset: 1<<SHIFT_DIV)
//  gains_valid    out  1       1-cycle pulse when new gains are loaded (reset 0)
//  busy           out  1       high while the divider FSM is not in IDLE (reset 0)
//  frame_dropped  out  1       1-cycle pulse: frame_end arrived while busy (reset 0)
// BEHAVIOUR
//  Accumulate: on rgb_in_valid with no channel >= SAT_THRESH, add R/G/B to sum_r/g/b
//   and increment pix_cnt (ACC_W bits). All accumulators saturate at all-ones; no wrap.
//  frame_start clears sum_*/pix_cnt. A valid pixel in the same cycle is the first pixel
//   of the new frame. frame_start and frame_end together: frame_end is processed first,
//   on the pre-clear sums.
//  frame_end, FSM IDLE: latch sum_r, sum_g, sum_b and pix_cnt into operand registers,
//   including any valid pixel in the same cycle. Accumulators continue independently,
//   so the next frame accumulates while the division runs.
//  frame_end, FSM not IDLE: pulse frame_dropped; operands and FSM are untouched.
//  FSM: IDLE -> (frame_end) CHECK -> DIV_R -> DIV_B -> UPDATE -> IDLE.
//   CHECK (1 cyc): pix_cnt < MIN_PIXELS -> IDLE; no gains_valid, gains hold.
//   DIV_R: q = (sum_g << SHIFT_DIV) / sum_r, restoring division, 1 quotient bit/cycle,
//     N = ACC_W+SHIFT_DIV cycles (34 at defaults). Dividend is ACC_W+SHIFT_DIV bits wide.
//   DIV_B: same as DIV_R with sum_b as divisor.
//   UPDATE (1 cyc): clamp each q to [1, GAIN_MAX], load gain_red/gain_blue, pulse
//     gains_valid.
//  Divisor == 0: result is GAIN_MAX, no division is run, and the state still takes
//   N cycles so latency is fixed.
//  Latency: frame_end in cycle 0 -> gains_valid in cycle 2N+2 (70 at defaults).
//  Gain outputs change only in the cycle gains_valid pulses; they are stable otherwise.
//  rst_n low in any state: FSM -> IDLE; accumulators, operands and pix_cnt cleared;
//   outputs take their reset values; any division in progress is discarded.
// STRUCTURE
//  Package awb_pkg:
//   - FSM state enum {IDLE, CHECK, DIV_R, DIV_B, UPDATE}
//   - localparams UNITY_GAIN, GAIN_MAX, DIV_CYCLES
//   - clamp function
//  Sub-module awb_seq_divider: start/done handshake, ACC_W+SHIFT_DIV cycle restoring
//   divider, divide-by-zero flag. Instantiated once and reused for R and then B.
//  Top level holds the accumulators, operand latches, FSM and output registers.
// TESTING
//  1. Reset, then 16 pixels of 0x808080, then frame_end -> gains_valid at +70 cycles
//     with gains 4/4/4.
//  2. 16 pixels of 0x408020 -> q_r = 2048*4/1024 = 8, q_b = 16 clamped to 15;
//     gain_red=8, gain_blue=15.
//  3. 16 pixels of 0x008080 -> sum_r = 0, gain_red = 15, gain_blue = 4; latency
//     still 70 cycles.
//  4. 16 pixels of 0x808080 plus 4 pixels of 0xFF8080 -> saturated pixels excluded;
//     gains 4/4/4. Then a frame with only 8 pixels -> no gains_valid, gains hold.
//  5. Second frame_end 20 cycles after the first -> frame_dropped pulses once, and the
//     first result is still delivered at +70 cycles.
//  6. Deassert rst_n during DIV_B -> outputs return to reset values, busy = 0, and no
//     gains_valid follows.

Source files
------------

// File: rtl/awb_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the AWB gain estimator.
package awb_pkg;

    localparam int SHIFT_DIV  = 2;
    localparam int GAIN_W     = 4;
    localparam int ACC_W      = 32;
    localparam int MIN_PIXELS = 16;
    localparam logic [7:0] SAT_THRESH = 8'hF0;

    localparam int DIV_W      = ACC_W + SHIFT_DIV;
    localparam int DIV_CYCLES = DIV_W;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1 << SHIFT_DIV);
    localparam logic [GAIN_W-1:0] GAIN_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_R,
        DIV_B,
        UPDATE
    } awb_state_t;

    // A zero quotient would black out the channel, so the floor is one LSB.
    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [DIV_W-1:0] q);
        if (q == '0) begin
            return GAIN_W'(1);
        end
        if (q > DIV_W'(GAIN_MAX)) begin
            return GAIN_MAX;
        end
        return q[GAIN_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/awb_seq_divider.sv
// Restoring divider, one quotient bit per cycle; the first bit is produced in the start cycle.
module awb_seq_divider
    import awb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [ACC_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             div_by_zero,
    output logic             done
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [ACC_W-1:0] rem_q;
    logic [ACC_W-1:0] div_q;
    logic [DIV_W-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic             dz_q;
    logic             done_q;

    logic [ACC_W-1:0] src_rem;
    logic [ACC_W-1:0] src_div;
    logic [DIV_W-1:0] src_quo;
    logic [ACC_W:0]   trial;
    logic [ACC_W-1:0] diff;
    logic [ACC_W-1:0] step_rem;
    logic [DIV_W-1:0] step_quo;

    // On start the step works on the fresh operands so the result lands after DIV_CYCLES edges.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        trial   = {src_rem, src_quo[DIV_W-1]};
        diff    = trial[ACC_W-1:0] - src_div;
        if (trial >= {1'b0, src_div}) begin
            step_rem = diff;
            step_quo = {src_quo[DIV_W-2:0], 1'b1};
        end else begin
            step_rem = trial[ACC_W-1:0];
            step_quo = {src_quo[DIV_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                div_q     <= divisor;
                dz_q      <= (divisor == '0);
                cnt_q     <= CNT_W'(1);
                running_q <= 1'b1;
                if (divisor == '0) begin
                    rem_q <= '0;
                    quo_q <= '1;
                end else begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                end
            end else if (running_q) begin
                // A zero divisor still counts out the full length to keep latency fixed.
                if (!dz_q) begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                end
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign quotient    = quo_q;
    assign div_by_zero = dz_q;
    assign done        = done_q;

endmodule

// File: rtl/awb_gain_estimator.sv
// Per-frame R/G/B accumulation and sequential computation of red/blue white-balance gains.
module awb_gain_estimator
    import awb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [23:0]       rgb_in,
    input  logic              rgb_in_valid,
    input  logic              frame_start,
    input  logic              frame_end,
    output logic [GAIN_W-1:0] gain_red,
    output logic [GAIN_W-1:0] gain_green,
    output logic [GAIN_W-1:0] gain_blue,
    output logic              gains_valid,
    output logic              busy,
    output logic              frame_dropped
);

    awb_state_t state_q;
    awb_state_t state_d;

    logic [ACC_W-1:0] sum_r_q, sum_g_q, sum_b_q, pix_cnt_q;
    logic [ACC_W-1:0] op_r_q, op_g_q, op_b_q, op_cnt_q;
    logic [ACC_W-1:0] px_r, px_g, px_b, px_one;
    logic [ACC_W-1:0] add_r, add_g, add_b, add_cnt;
    logic             pixel_ok;
    logic             end_accept;
    logic             enough_pixels;

    logic             div_start;
    logic             div_done;
    logic             div_dz;
    logic [DIV_W-1:0] div_dividend;
    logic [ACC_W-1:0] div_divisor;
    logic [DIV_W-1:0] div_quotient;
    logic [DIV_W-1:0] div_result;
    logic [DIV_W-1:0] q_r_q;

    logic [GAIN_W-1:0] gain_red_q;
    logic [GAIN_W-1:0] gain_blue_q;
    logic              dropped_q;

    always_comb begin
        pixel_ok   = rgb_in_valid && (rgb_in[23:16] < SAT_THRESH) &&
                     (rgb_in[15:8] < SAT_THRESH) && (rgb_in[7:0] < SAT_THRESH);
        px_r       = pixel_ok ? ACC_W'(rgb_in[23:16]) : '0;
        px_g       = pixel_ok ? ACC_W'(rgb_in[15:8])  : '0;
        px_b       = pixel_ok ? ACC_W'(rgb_in[7:0])   : '0;
        px_one     = pixel_ok ? ACC_W'(1) : '0;
        add_r      = sat_add(sum_r_q, px_r);
        add_g      = sat_add(sum_g_q, px_g);
        add_b      = sat_add(sum_b_q, px_b);
        add_cnt    = sat_add(pix_cnt_q, px_one);
        end_accept = frame_end && (state_q == IDLE);
    end

    // With frame_start, a same-cycle pixel opens the new frame instead of extending the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r_q   <= '0;
            sum_g_q   <= '0;
            sum_b_q   <= '0;
            pix_cnt_q <= '0;
        end else if (frame_start) begin
            sum_r_q   <= px_r;
            sum_g_q   <= px_g;
            sum_b_q   <= px_b;
            pix_cnt_q <= px_one;
        end else begin
            sum_r_q   <= add_r;
            sum_g_q   <= add_g;
            sum_b_q   <= add_b;
            pix_cnt_q <= add_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r_q   <= '0;
            op_g_q   <= '0;
            op_b_q   <= '0;
            op_cnt_q <= '0;
        end else if (end_accept) begin
            op_r_q   <= frame_start ? sum_r_q   : add_r;
            op_g_q   <= frame_start ? sum_g_q   : add_g;
            op_b_q   <= frame_start ? sum_b_q   : add_b;
            op_cnt_q <= frame_start ? pix_cnt_q : add_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_end) state_d = CHECK;
            CHECK:   state_d = enough_pixels ? DIV_R : IDLE;
            DIV_R:   if (div_done) state_d = DIV_B;
            DIV_B:   if (div_done) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The red division is launched from CHECK and blue on red's done, so both finish on schedule.
    always_comb begin
        enough_pixels = (op_cnt_q >= ACC_W'(MIN_PIXELS));
        busy          = (state_q != IDLE);
        gains_valid   = (state_q == UPDATE);
        div_start     = ((state_q == CHECK) && enough_pixels) ||
                        ((state_q == DIV_R) && div_done);
        div_dividend  = {op_g_q, {SHIFT_DIV{1'b0}}};
        div_divisor   = (state_q == DIV_R) ? op_b_q : op_r_q;
        div_result    = div_dz ? '1 : div_quotient;
    end

    awb_seq_divider u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (div_start),
        .dividend    (div_dividend),
        .divisor     (div_divisor),
        .quotient    (div_quotient),
        .div_by_zero (div_dz),
        .done        (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r_q       <= '0;
            gain_red_q  <= UNITY_GAIN;
            gain_blue_q <= UNITY_GAIN;
            dropped_q   <= 1'b0;
        end else begin
            dropped_q <= frame_end && (state_q != IDLE);
            if ((state_q == DIV_R) && div_done) begin
                q_r_q <= div_result;
            end
            if ((state_q == DIV_B) && div_done) begin
                gain_red_q  <= clamp_gain(q_r_q);
                gain_blue_q <= clamp_gain(div_result);
            end
        end
    end

    assign gain_red      = gain_red_q;
    assign gain_green    = UNITY_GAIN;
    assign gain_blue     = gain_blue_q;
    assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_awb_gain_estimator.sv
// Self-checking bench for awb_gain_estimator: directed table, hand sequences and random frames.
module tb_awb_gain_estimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        rgb_in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic [3:0]  gain_red, gain_green, gain_blue;
    logic        gains_valid, busy, frame_dropped;

    always #5 clk = ~clk;

    awb_gain_estimator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rgb_in        (rgb_in),
        .rgb_in_valid  (rgb_in_valid),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .gain_red      (gain_red),
        .gain_green    (gain_green),
        .gain_blue     (gain_blue),
        .gains_valid   (gains_valid),
        .busy          (busy),
        .frame_dropped (frame_dropped)
    );

    typedef struct {
        string       name;
        logic [23:0] px_a;
        int          n_a;
        logic [23:0] px_b;
        int          n_b;
        bit          exp_valid;
        int          exp_r;
        int          exp_b;
    } vec_t;

    localparam int WINDOW = 100;
    localparam int LATENCY = 70;

    vec_t       vecs[5];
    logic [24:0] frame_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         res_lat, res_valid_cnt, res_dropped, res_unstable;
    int         res_busy_mid, res_rst_r, res_rst_b, res_rst_busy, res_rst_valid;
    int         res_r, res_b;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Frame: frame_start cycle, queued pixels, frame_end, then a monitored window.
    task automatic applyStimulus(input int second_end_at, input int reset_at);
        logic [3:0] prev_r, prev_b;
        @(negedge clk);
        frame_start  = 1'b1;
        rgb_in_valid = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        foreach (frame_q[i]) begin
            rgb_in       = frame_q[i][23:0];
            rgb_in_valid = frame_q[i][24];
            @(negedge clk);
        end
        rgb_in_valid  = 1'b0;
        frame_end     = 1'b1;
        prev_r        = gain_red;
        prev_b        = gain_blue;
        res_lat       = -1;
        res_valid_cnt = 0;
        res_dropped   = 0;
        res_unstable  = 0;
        res_busy_mid  = -1;
        res_rst_r     = -1;
        res_rst_b     = -1;
        res_rst_busy  = -1;
        res_rst_valid = -1;
        for (int c = 1; c <= WINDOW; c++) begin
            @(negedge clk);
            frame_end = (c == second_end_at);
            if (c == reset_at) rst_n = 1'b0;
            if (c == reset_at + 2) rst_n = 1'b1;
            if (gains_valid) begin
                res_valid_cnt++;
                if (res_lat < 0) res_lat = c;
            end else if (rst_n && (gain_red !== prev_r || gain_blue !== prev_b)) begin
                res_unstable++;
            end
            if (frame_dropped) res_dropped++;
            if (c == 30) res_busy_mid = int'(busy);
            if (c == reset_at + 1) begin
                res_rst_r     = int'(gain_red);
                res_rst_b     = int'(gain_blue);
                res_rst_busy  = int'(busy);
                res_rst_valid = int'(gains_valid);
            end
            prev_r = gain_red;
            prev_b = gain_blue;
        end
        res_r = int'(gain_red);
        res_b = int'(gain_blue);
    endtask

    function automatic int ref_gain(input longint num, input longint den);
        longint q;
        if (den == 0) return 15;
        q = (num * 4) / den;
        if (q < 1) return 1;
        if (q > 15) return 15;
        return int'(q);
    endfunction

    initial begin
        int exp_r, exp_b;
        vecs[0] = '{"unity",    24'h808080, 16, 24'h000000, 0, 1'b1, 4,  4};
        vecs[1] = '{"r_half",   24'h408020, 16, 24'h000000, 0, 1'b1, 8,  15};
        vecs[2] = '{"r_zero",   24'h008080, 16, 24'h000000, 0, 1'b1, 15, 4};
        vecs[3] = '{"short",    24'h408020, 8,  24'h000000, 0, 1'b0, 15, 4};
        vecs[4] = '{"sat_excl", 24'h808080, 16, 24'hFF8080, 4, 1'b1, 4,  4};

        repeat (3) @(negedge clk);
        checkOutput("rst_gain_red",   gain_red,      4);
        checkOutput("rst_gain_green", gain_green,    4);
        checkOutput("rst_gain_blue",  gain_blue,     4);
        checkOutput("rst_valid",      gains_valid,   0);
        checkOutput("rst_busy",       busy,          0);
        checkOutput("rst_dropped",    frame_dropped, 0);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            frame_q.delete();
            for (int i = 0; i < vecs[v].n_a; i++) frame_q.push_back({1'b1, vecs[v].px_a});
            for (int i = 0; i < vecs[v].n_b; i++) frame_q.push_back({1'b1, vecs[v].px_b});
            applyStimulus(0, 0);
            checkOutput({vecs[v].name, "_valid_cnt"}, res_valid_cnt, int'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) checkOutput({vecs[v].name, "_latency"}, res_lat, LATENCY);
            checkOutput({vecs[v].name, "_busy_mid"}, res_busy_mid, int'(vecs[v].exp_valid));
            checkOutput({vecs[v].name, "_gain_red"}, res_r, vecs[v].exp_r);
            checkOutput({vecs[v].name, "_gain_blue"}, res_b, vecs[v].exp_b);
            checkOutput({vecs[v].name, "_unstable"}, res_unstable, 0);
            checkOutput({vecs[v].name, "_dropped"}, res_dropped, 0);
        end

        // Second frame_end while dividing is dropped; the first result still arrives.
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back({1'b1, 24'h408020});
        applyStimulus(20, 0);
        checkOutput("drop_dropped",   res_dropped,   1);
        checkOutput("drop_valid_cnt", res_valid_cnt, 1);
        checkOutput("drop_latency",   res_lat,       LATENCY);
        checkOutput("drop_gain_red",  res_r,         8);
        checkOutput("drop_gain_blue", res_b,         15);
        checkOutput("drop_busy_end",  busy,          0);

        // Reset during the blue division discards the computation.
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back({1'b1, 24'h204080});
        applyStimulus(0, 50);
        checkOutput("rst_mid_gain_red",  res_rst_r,     4);
        checkOutput("rst_mid_gain_blue", res_rst_b,     4);
        checkOutput("rst_mid_busy",      res_rst_busy,  0);
        checkOutput("rst_mid_valid",     res_rst_valid, 0);
        checkOutput("rst_mid_valid_cnt", res_valid_cnt, 0);
        checkOutput("rst_mid_final_red", res_r,         4);

        exp_r = 4;
        exp_b = 4;
        for (int f = 0; f < 8; f++) begin
            longint sr, sg, sb;
            int     n, len;
            sr = 0; sg = 0; sb = 0; n = 0;
            frame_q.delete();
            len = $urandom_range(40, 10);
            for (int i = 0; i < len; i++) begin
                logic [7:0] r, g, b;
                logic       vld;
                r   = 8'($urandom_range(255, 0));
                g   = 8'($urandom_range(255, 0));
                b   = 8'($urandom_range(255, 0));
                if ($urandom_range(7, 0) == 0) r = 8'hF8;
                vld = ($urandom_range(3, 0) != 0);
                frame_q.push_back({vld, r, g, b});
                if (vld && r < 8'd240 && g < 8'd240 && b < 8'd240) begin
                    sr += r; sg += g; sb += b; n++;
                end
            end
            if (n >= 16) begin
                exp_r = ref_gain(sg, sr);
                exp_b = ref_gain(sg, sb);
            end
            applyStimulus(0, 0);
            checkOutput($sformatf("rand%0d_valid_cnt", f), res_valid_cnt, (n >= 16) ? 1 : 0);
            if (n >= 16) checkOutput($sformatf("rand%0d_latency", f), res_lat, LATENCY);
            checkOutput($sformatf("rand%0d_gain_red", f), res_r, exp_r);
            checkOutput($sformatf("rand%0d_gain_blue", f), res_b, exp_b);
            checkOutput($sformatf("rand%0d_dropped", f), res_dropped, 0);
        end

        checkOutput("final_gain_green", gain_green, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
